// File: rtl/mmu_bus_if.sv
// mmu_bus_if: bus bundle between the CPU/device side and the mmu_bus sequencer.
//
// Parameters:
//   NUM_DEV  number of device windows
//   SEL_LSB  width of the device-local address
//
// Signals:
//   REQ, WR, ADDR, IN      CPU request (command, direction, byte address, write data)
//   OUT, ACK, FAULT        CPU response (read data, completion pulse, rejection flag)
//   DEV_ADDR, DEV_IN       latched device-local address and write data
//   DEV_OUT                read data from every device, device d at [32d+31:32d]
//   DEV_N_WE, DEV_N_OE     per-device active-low write/read strobes
//
// Handshake: REQ is sampled only while the sequencer is ready (ACK high or idle).
// ACK is a one-cycle pulse; FAULT qualifies it. A REQ while busy is dropped.
//
// Modports:
//   slave  - the sequencer's view
//   master - the environment's view (CPU plus devices)
interface mmu_bus_if #(
    parameter int NUM_DEV = 2,
    parameter int SEL_LSB = 16
);
    logic                    REQ;
    logic                    WR;
    logic [31:0]             ADDR;
    logic [31:0]             IN;
    logic [31:0]             OUT;
    logic                    ACK;
    logic                    FAULT;
    logic [SEL_LSB-1:0]      DEV_ADDR;
    logic [31:0]             DEV_IN;
    logic [NUM_DEV*32-1:0]   DEV_OUT;
    logic [NUM_DEV-1:0]      DEV_N_WE;
    logic [NUM_DEV-1:0]      DEV_N_OE;

    modport slave (
        input  REQ, WR, ADDR, IN, DEV_OUT,
        output OUT, ACK, FAULT, DEV_ADDR, DEV_IN, DEV_N_WE, DEV_N_OE
    );

    modport master (
        output REQ, WR, ADDR, IN, DEV_OUT,
        input  OUT, ACK, FAULT, DEV_ADDR, DEV_IN, DEV_N_WE, DEV_N_OE
    );
endinterface

// File: rtl/mmu_bus.sv
// mmu_bus: registered sequencer that decodes a 32-bit CPU address into one of
// NUM_DEV device windows and runs a strobe/ACK transaction with a per-device
// wait-state count. Unaligned or unmapped addresses complete with FAULT.
//
// Ports:
//   CLK        clock, rising edge
//   N_RST      asynchronous active-low reset
//   bus        mmu_bus_if.slave (CPU request/response and device strobes)
//   DBG_STATE  current FSM state (0 IDLE, 1 ACCESS, 2 DONE, 3 FAULT)
module mmu_bus #(
    parameter int                   NUM_DEV     = 2,
    parameter int                   SEL_LSB     = 16,
    parameter logic [4*NUM_DEV-1:0] WAIT_CYCLES = 8'h10
) (
    input  logic        CLK,
    input  logic        N_RST,
    mmu_bus_if.slave    bus,
    output logic [1:0]  DBG_STATE
);
    localparam int SEL_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int TOP   = SEL_LSB + SEL_W;
    // Address bits above the device index must be zero for a mapped access.
    localparam logic [31:0] HI_MASK = (TOP >= 32) ? 32'h0 : ~((32'h1 << TOP) - 32'h1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               load;
    logic [SEL_W-1:0]   req_idx;
    logic               req_hit;
    logic               req_bad;
    logic [3:0]         req_wait;
    logic [SEL_W-1:0]   sel_q;
    logic [3:0]         cnt_q;
    logic               wr_q;
    logic [31:0]        out_q;
    logic [SEL_LSB-1:0] dev_addr_q;
    logic [31:0]        dev_in_q;
    logic [31:0]        rd_data;
    logic [NUM_DEV-1:0] n_we;
    logic [NUM_DEV-1:0] n_oe;

    assign req_idx = bus.ADDR[SEL_LSB +: SEL_W];

    // Decode the incoming request: window hit and its wait count.
    always_comb begin
        req_hit  = 1'b0;
        req_wait = 4'd0;
        for (int d = 0; d < NUM_DEV; d++) begin
            if (req_idx == SEL_W'(d)) begin
                req_hit  = 1'b1;
                req_wait = WAIT_CYCLES[4*d +: 4];
            end
        end
        req_bad = (bus.ADDR[1:0] != 2'b00) || !req_hit || ((bus.ADDR & HI_MASK) != 32'h0);
    end

    // Read data of the latched device.
    always_comb begin
        rd_data = 32'h0;
        for (int d = 0; d < NUM_DEV; d++) begin
            if (sel_q == SEL_W'(d)) rd_data = bus.DEV_OUT[32*d +: 32];
        end
    end

    // Next-state logic. Ready states accept REQ; ACCESS ignores it.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_ACCESS: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
            end
            default: begin
                if (bus.REQ) begin
                    load    = 1'b1;
                    state_d = req_bad ? S_FAULT : S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            sel_q      <= '0;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            out_q      <= 32'h0;
            dev_addr_q <= '0;
            dev_in_q   <= 32'h0;
        end else begin
            if (load) begin
                sel_q      <= req_idx;
                cnt_q      <= req_bad ? 4'd0 : req_wait;
                wr_q       <= bus.WR;
                dev_addr_q <= bus.ADDR[SEL_LSB-1:0];
                dev_in_q   <= bus.IN;
            end else if (state_q == S_ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Capture read data on the edge that leaves ACCESS.
            if (state_q == S_ACCESS && cnt_q == 4'd0 && !wr_q) out_q <= rd_data;
        end
    end

    // Strobes derive from the registered state so an asynchronous reset
    // releases them immediately.
    always_comb begin
        n_we = '1;
        n_oe = '1;
        for (int d = 0; d < NUM_DEV; d++) begin
            if (state_q == S_ACCESS && sel_q == SEL_W'(d)) begin
                if (wr_q) n_we[d] = 1'b0;
                else      n_oe[d] = 1'b0;
            end
        end
    end

    assign bus.DEV_N_WE = n_we;
    assign bus.DEV_N_OE = n_oe;
    assign bus.OUT      = out_q;
    assign bus.DEV_ADDR = dev_addr_q;
    assign bus.DEV_IN   = dev_in_q;
    assign bus.ACK      = (state_q == S_DONE) || (state_q == S_FAULT);
    assign bus.FAULT    = (state_q == S_FAULT);
    assign DBG_STATE    = state_q;
endmodule

// File: tb/tb_mmu_bus.sv
module tb_mmu_bus;
  logic       CLK;
  logic       N_RST;
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;
  int         checks;
  int         errors;

  mmu_bus_if #(.NUM_DEV(2), .SEL_LSB(16)) bus_a ();
  mmu_bus_if #(.NUM_DEV(3), .SEL_LSB(16)) bus_b ();

  mmu_bus #(.NUM_DEV(2), .SEL_LSB(16), .WAIT_CYCLES(8'h10)) dut_a (
    .CLK(CLK), .N_RST(N_RST), .bus(bus_a.slave), .DBG_STATE(dbg_a)
  );
  mmu_bus #(.NUM_DEV(3), .SEL_LSB(16), .WAIT_CYCLES(12'hF20)) dut_b (
    .CLK(CLK), .N_RST(N_RST), .bus(bus_b.slave), .DBG_STATE(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit          b;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    int          lat;
    int          strobes;
    logic [2:0]  we_exp;
    logic [2:0]  oe_exp;
    logic        fault;
    logic [31:0] out_exp;
  } vec_t;

  vec_t vecs[13];

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input bit b, input logic wr, input logic [31:0] addr,
                         input logic [31:0] din, output int lat, output int strobes,
                         output logic [2:0] we_and, output logic [2:0] oe_and,
                         output logic fault, output logic [31:0] out,
                         output bit stable_ok, output bit onehot_ok, output bit ack_after);
    logic [2:0]  we;
    logic [2:0]  oe;
    logic        ack;
    logic [15:0] da;
    logic [31:0] di;
    bit          done;
    lat = 0; strobes = 0; we_and = 3'b111; oe_and = 3'b111; fault = 1'b0;
    stable_ok = 1'b1; onehot_ok = 1'b1; done = 1'b0; out = 32'h0;
    if (!b) begin
      bus_a.WR = wr; bus_a.ADDR = addr; bus_a.IN = din; bus_a.REQ = 1'b1;
    end else begin
      bus_b.WR = wr; bus_b.ADDR = addr; bus_b.IN = din; bus_b.REQ = 1'b1;
    end
    for (int c = 0; c < 64; c++) begin
      @(posedge CLK); #1;
      bus_a.REQ = 1'b0; bus_b.REQ = 1'b0;
      lat++;
      if (!b) begin
        we = {1'b1, bus_a.DEV_N_WE}; oe = {1'b1, bus_a.DEV_N_OE};
        ack = bus_a.ACK; fault = bus_a.FAULT; da = bus_a.DEV_ADDR; di = bus_a.DEV_IN;
        out = bus_a.OUT;
      end else begin
        we = bus_b.DEV_N_WE; oe = bus_b.DEV_N_OE;
        ack = bus_b.ACK; fault = bus_b.FAULT; da = bus_b.DEV_ADDR; di = bus_b.DEV_IN;
        out = bus_b.OUT;
      end
      if ($countones(~{we, oe}) > 1) onehot_ok = 1'b0;
      if ({we, oe} != 6'b111111) begin
        strobes++;
        we_and &= we;
        oe_and &= oe;
        if (da != addr[15:0] || (wr && di != din)) stable_ok = 1'b0;
      end
      if (ack) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) $display("FAIL txn_timeout: no ACK within 64 cycles for addr %h", addr);
    @(posedge CLK); #1;
    ack_after = b ? bus_b.ACK : bus_a.ACK;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, strobes;
    logic [2:0]  we_and, oe_and;
    logic        fault;
    logic [31:0] out;
    bit          stable_ok, onehot_ok, ack_after;
    int          gaps[4];
    logic [31:0] outs[4];
    int          n, cyc, last;
    bit          done_strobe_bad, overlap_bad, ack_seen;
    logic [31:0] exp_q[$];

    checks = 0; errors = 0;
    N_RST = 1'b0;
    bus_a.REQ = 1'b0; bus_a.WR = 1'b0; bus_a.ADDR = 32'h0; bus_a.IN = 32'h0;
    bus_b.REQ = 1'b0; bus_b.WR = 1'b0; bus_b.ADDR = 32'h0; bus_b.IN = 32'h0;
    bus_a.DEV_OUT = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    bus_b.DEV_OUT = {32'h2B2B_2B2B, 32'h1B1B_1B1B, 32'h0B0B_0B0B};

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         2,  1,  3'b111, 3'b110, 1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 1'b1, 32'h0001_0004, 32'h1234_5678, 3,  2,  3'b101, 3'b111, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0002, 32'h0,         1,  0,  3'b111, 3'b111, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'h0002_0000, 32'h0,         1,  0,  3'b111, 3'b111, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b0, 32'h0001_0008, 32'h0,         3,  2,  3'b111, 3'b101, 1'b0, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         1,  0,  3'b111, 3'b111, 1'b1, 32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_FFFC, 32'hA5A5_5A5A, 2,  1,  3'b110, 3'b111, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 1'b0, 32'h0001_0001, 32'h0,         1,  0,  3'b111, 3'b111, 1'b1, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 1'b0, 32'h0002_0020, 32'h0,         17, 16, 3'b111, 3'b011, 1'b0, 32'h2B2B_2B2B};
    vecs[9]  = '{1'b1, 1'b0, 32'h0003_0000, 32'h0,         1,  0,  3'b111, 3'b111, 1'b1, 32'h2B2B_2B2B};
    vecs[10] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,         4,  3,  3'b111, 3'b101, 1'b0, 32'h1B1B_1B1B};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0F0F_F0F0, 2,  1,  3'b110, 3'b111, 1'b0, 32'h1B1B_1B1B};
    vecs[12] = '{1'b1, 1'b0, 32'h0004_0000, 32'h0,         1,  0,  3'b111, 3'b111, 1'b1, 32'h1B1B_1B1B};

    // Reset held for 3 cycles.
    repeat (3) @(posedge CLK);
    #2 N_RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_out",   bus_a.OUT, 32'h0);
    chk("rst_ack",   {31'h0, bus_a.ACK}, 32'h0);
    chk("rst_fault", {31'h0, bus_a.FAULT}, 32'h0);
    chk("rst_we",    {30'h0, bus_a.DEV_N_WE}, 32'h3);
    chk("rst_oe",    {30'h0, bus_a.DEV_N_OE}, 32'h3);
    chk("rst_addr",  {16'h0, bus_a.DEV_ADDR}, 32'h0);
    chk("rst_in",    bus_a.DEV_IN, 32'h0);
    chk("rst_state", {30'h0, dbg_a}, 32'h0);
    chk("rst_b_oe",  {29'h0, bus_b.DEV_N_OE}, 32'h7);

    // Table-driven single transactions.
    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i].b, vecs[i].wr, vecs[i].addr, vecs[i].din, lat, strobes,
              we_and, oe_and, fault, out, stable_ok, onehot_ok, ack_after);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_strobe_cycles", i), 32'(strobes), 32'(vecs[i].strobes));
      chk($sformatf("v%0d_we", i), {29'h0, we_and}, {29'h0, vecs[i].we_exp});
      chk($sformatf("v%0d_oe", i), {29'h0, oe_and}, {29'h0, vecs[i].oe_exp});
      chk($sformatf("v%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].fault});
      chk($sformatf("v%0d_out", i), out, vecs[i].out_exp);
      chk($sformatf("v%0d_addr_in_stable", i), {31'h0, stable_ok}, 32'h1);
      chk($sformatf("v%0d_strobe_onehot", i), {31'h0, onehot_ok}, 32'h1);
      chk($sformatf("v%0d_ack_pulse", i), {31'h0, ack_after}, 32'h0);
    end

    // Back-to-back alternating dev0/dev1 reads with REQ held high.
    exp_q = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    bus_a.WR = 1'b0; bus_a.ADDR = 32'h0000_0010; bus_a.REQ = 1'b1;
    n = 0; cyc = 0; last = 0; done_strobe_bad = 1'b0; overlap_bad = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge CLK); #1;
      cyc++;
      if ($countones(~{bus_a.DEV_N_WE, bus_a.DEV_N_OE}) > 1) overlap_bad = 1'b1;
      if (bus_a.ACK) begin
        gaps[n] = cyc - last;
        last = cyc;
        outs[n] = bus_a.OUT;
        if ({bus_a.DEV_N_WE, bus_a.DEV_N_OE} != 4'hF) done_strobe_bad = 1'b1;
        n++;
        if (n == 4) bus_a.REQ = 1'b0;
        else        bus_a.ADDR = (n % 2 == 1) ? 32'h0001_0000 : 32'h0000_0010;
      end
    end
    bus_a.REQ = 1'b0;
    chk("b2b_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        chk($sformatf("b2b_gap%0d", i), 32'(gaps[i]), (i % 2 == 0) ? 32'd2 : 32'd3);
        chk($sformatf("b2b_out%0d", i), outs[i], exp_q[i]);
      end
    end
    chk("b2b_strobe_in_done", {31'h0, done_strobe_bad}, 32'h0);
    chk("b2b_overlap", {31'h0, overlap_bad}, 32'h0);
    @(posedge CLK); #1;
    chk("b2b_idle", {30'h0, dbg_a}, 32'h0);

    // Reset in the middle of a long ACCESS on the 3-device instance.
    bus_b.WR = 1'b0; bus_b.ADDR = 32'h0002_0000; bus_b.REQ = 1'b1;
    @(posedge CLK); #1;
    bus_b.REQ = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("midrst_strobe_low", {29'h0, bus_b.DEV_N_OE}, 32'h3);
    #2 N_RST = 1'b0;
    #1;
    chk("midrst_strobe_async", {29'h0, bus_b.DEV_N_OE}, 32'h7);
    chk("midrst_state", {30'h0, dbg_b}, 32'h0);
    @(posedge CLK);
    #2 N_RST = 1'b1;
    ack_seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge CLK); #1;
      if (bus_b.ACK) ack_seen = 1'b1;
    end
    chk("midrst_no_ack", {31'h0, ack_seen}, 32'h0);
    chk("midrst_out_cleared", bus_b.OUT, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmu_bus.md
# mmu_bus

Parametrised, clocked memory-management bus controller that decodes a 32-bit CPU address into one of NUM_DEV device windows and runs a REQ/ACK transaction against the selected device. Each device has its own wait-state count, and the block raises a fault for unaligned or unmapped accesses. It sits between the CPU bus and the SRAM/VGA/peripheral blocks, replacing purely combinational strobe gating with a registered sequencer.

## Interface
Parameters:
- NUM_DEV, 2: number of device windows, 1..16; index width SEL_W = max(1, clog2(NUM_DEV)).
- SEL_LSB, 16: lowest address bit of the device index; device-local address is ADDR[SEL_LSB-1:0].
- WAIT_CYCLES, 8'h10: packed 4-bit wait count per device, device d at [4d+3:4d]; default is dev0 = 0, dev1 = 1.

Ports:
- CLK  in  1  sole clock; all state changes on rising edge.
- N_RST  in  1  reset, asynchronous, active-low.
- REQ  in  1  start transaction; sampled only when ready (IDLE, DONE or FAULT).
- WR  in  1  1 = write, 0 = read; sampled with REQ.
- ADDR  in  32  byte address; sampled with REQ.
- IN  in  32  write data; sampled with REQ.
- OUT  out  32  read data, registered; valid while ACK = 1.
- ACK  out  1  one-cycle completion pulse.
- FAULT  out  1  high with ACK when the transaction was rejected.
- DEV_ADDR  out  SEL_LSB  latched device-local address.
- DEV_IN  out  32  latched write data.
- DEV_OUT  in  NUM_DEV*32  read data from each device, device d at [32d+31:32d].
- DEV_N_WE  out  NUM_DEV  per-device write strobe, active-low.
- DEV_N_OE  out  NUM_DEV  per-device read strobe, active-low.

## Operation
- States: IDLE, ACCESS, DONE, FAULT.
- Ready states: IDLE, DONE, FAULT. In a ready state, REQ = 1 latches WR, ADDR, IN and decodes idx = ADDR[SEL_LSB +: SEL_W].
- Fault conditions, any of: ADDR[1:0] != 0; idx >= NUM_DEV; any ADDR bit above SEL_LSB+SEL_W-1 set. On fault go to FAULT. No strobe is asserted and the latched DEV_ADDR/DEV_IN are not driven to any device.
- Otherwise go to ACCESS and load the wait counter with WAIT_CYCLES[idx].
- ACCESS: DEV_N_OE[idx] (read) or DEV_N_WE[idx] (write) is low. The counter decrements each cycle. When the counter is 0, transition to DONE; on a read, that same edge registers DEV_OUT[idx] into OUT. REQ is ignored in ACCESS.
- DONE: ACK = 1, FAULT = 0, all strobes high. With REQ = 1, start the next transaction; otherwise go to IDLE.
- FAULT: ACK = 1, FAULT = 1, all strobes high, OUT unchanged. With REQ = 1, start the next transaction; otherwise go to IDLE.
- Invariants:
  - At most one bit of DEV_N_WE and DEV_N_OE combined is low.
  - Strobes are low only in ACCESS.
  - DEV_ADDR and DEV_IN are stable for the whole ACCESS period.
  - OUT changes only on a completed read.

## Timing
- Reset (N_RST low, asynchronous): state IDLE, DEV_N_WE and DEV_N_OE all ones, ACK = 0, FAULT = 0, OUT = 0, DEV_ADDR = 0, DEV_IN = 0, counter = 0.
- Reset mid-ACCESS deasserts the strobe immediately, without waiting for a clock edge, and discards the transaction. No ACK follows.
- With REQ sampled at edge k and W = WAIT_CYCLES[idx]:
  - Strobe is low from edge k+1 to edge k+W+2, i.e. W+1 cycles.
  - ACK is high from edge k+W+2 to edge k+W+3.
  - Read latency to ACK is W+2 cycles.
- Fault: ACK and FAULT are high from edge k+1 for one cycle.
- Back-to-back: REQ held high gives one transaction per W+2 cycles. The strobe is high for exactly the DONE cycle between accesses.
- Simultaneous events: REQ during ACCESS is dropped, not queued, and the host must wait for ACK. A new REQ in DONE/FAULT takes effect while ACK of the previous transaction is still visible that cycle.

## Test plan
- Reset: hold N_RST low for 3 cycles, then release -> OUT = 0, ACK = 0, FAULT = 0, all strobes 1. Assert N_RST mid-ACCESS -> strobe high with no clock edge, and no ACK follows.
- Read dev0, W = 0: preload DEV_OUT[31:0] = 32'hDEADBEEF, REQ with ADDR = 32'h0000_0010, WR = 0 -> DEV_N_OE = 2'b10 for exactly 1 cycle, DEV_ADDR = 16'h0010, ACK two cycles after REQ, OUT = 32'hDEADBEEF.
- Write dev1, W = 1: ADDR = 32'h0001_0004, IN = 32'h1234_5678 -> DEV_N_WE = 2'b01 for 2 cycles with DEV_IN = 32'h1234_5678, ACK three cycles after REQ, FAULT = 0, OUT unchanged.
- Faults: ADDR = 32'h0000_0002 -> ACK = 1 and FAULT = 1 one cycle after REQ. ADDR = 32'h0002_0000 -> same response. No strobe is asserted in either case.
- Back-to-back: REQ held high for 4 alternating dev0/dev1 reads -> ACK pulses 2 cycles then 3 cycles apart. Strobes never overlap and are high during each DONE cycle.
- Parametrisation: NUM_DEV = 3, WAIT_CYCLES = 12'hF20, read idx 2 -> strobe low for 16 cycles, ACK 17 cycles after REQ. Idx 3 -> FAULT.
